// File: rtl/tnaf_digit_stack_if.sv
// Digit-stream bus between the tau-NAF generator, the digit stack and the
// point-multiplication controller. The stack uses "slave", the environment "master".
interface tnaf_digit_stack_if #(
  parameter int AW = 9
);
  logic          start;
  logic          wr_valid;
  logic          wr_nonzero;
  logic          wr_sign;
  logic          gen_done;
  logic          suspend;
  logic          rd_req;
  logic          rd_valid;
  logic          rd_nonzero;
  logic          rd_sign;
  logic          rd_last;
  logic [AW:0]   length;
  logic [AW:0]   weight;
  logic          length_even;
  logic          ready;
  logic          done;
  logic          overflow;

  modport slave (
    input  start, wr_valid, wr_nonzero, wr_sign, gen_done, rd_req,
    output suspend, rd_valid, rd_nonzero, rd_sign, rd_last,
           length, weight, length_even, ready, done, overflow
  );

  modport master (
    output start, wr_valid, wr_nonzero, wr_sign, gen_done, rd_req,
    input  suspend, rd_valid, rd_nonzero, rd_sign, rd_last,
           length, weight, length_even, ready, done, overflow
  );
endinterface

// File: rtl/tnaf_digit_stack.sv
// LIFO for tau-NAF digits: stacked LSB-first, leading zeros trimmed,
// popped MSB-first with length/weight/parity reporting.
module tnaf_digit_stack #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic              clk,
  input  logic              rst,
  tnaf_digit_stack_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_TRIM,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW:0] weight_q, weight_d;
  logic [AW:0] length_q, length_d;
  logic        overflow_q, overflow_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_nz_q, rd_nz_d;
  logic        rd_sign_q, rd_sign_d;
  logic        rd_last_q, rd_last_d;

  // {nonzero, sign}; sign is forced low for zero digits on write
  logic [1:0]    mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] top_idx;
  logic [1:0]    top;

  // Wraps to DEPTH-1 when the stack is full; only consulted when cnt_q > 0
  assign top_idx = cnt_q[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cnt_q[AW-1:0]] <= {bus.wr_nonzero, bus.wr_nonzero & bus.wr_sign};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      weight_q   <= '0;
      length_q   <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_nz_q    <= 1'b0;
      rd_sign_q  <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      weight_q   <= weight_d;
      length_q   <= length_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_nz_q    <= rd_nz_d;
      rd_sign_q  <= rd_sign_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    weight_d   = weight_q;
    length_d   = length_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_nz_d    = rd_nz_q;
    rd_sign_d  = rd_sign_q;
    rd_last_d  = rd_last_q;
    mem_we     = 1'b0;

    if (bus.start) begin
      state_d    = S_FILL;
      cnt_d      = '0;
      weight_d   = '0;
      length_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (bus.wr_valid && state_q != S_FILL) begin
        overflow_d = 1'b1;
      end

      unique case (state_q)
        S_FILL: begin
          if (bus.wr_valid) begin
            if (cnt_q != FULL) begin
              mem_we   = 1'b1;
              cnt_d    = cnt_q + (AW+1)'(1);
              weight_d = weight_q + (AW+1)'(bus.wr_nonzero);
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (bus.gen_done) begin
            state_d = S_TRIM;
          end
        end
        S_TRIM: begin
          if (cnt_q != '0 && !top[1]) begin
            cnt_d = cnt_q - (AW+1)'(1);
          end else begin
            length_d = cnt_q;
            state_d  = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else if (bus.rd_req) begin
            rd_valid_d = 1'b1;
            rd_nz_d    = top[1];
            rd_sign_d  = top[0];
            rd_last_d  = (cnt_q == (AW+1)'(1));
            cnt_d      = cnt_q - (AW+1)'(1);
          end
        end
        S_IDLE, S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.suspend     = (cnt_q == FULL);
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_nonzero  = rd_nz_q;
  assign bus.rd_sign     = rd_sign_q;
  assign bus.rd_last     = rd_last_q;
  assign bus.length      = length_q;
  assign bus.weight      = weight_q;
  assign bus.length_even = ~length_q[0];
  assign bus.ready       = (state_q == S_DRAIN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_tnaf_digit_stack.sv
// Directed bench for tnaf_digit_stack (DEPTH=8); popped digits are checked by a
// scoreboard monitor, status outputs by directed checks.
module tb_tnaf_digit_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [2:0] exp_q [$];   // {nonzero, sign, last}
  int   done_rises;

  tnaf_digit_stack_if #(.AW(AW)) ifc ();

  tnaf_digit_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic nz, input logic s, input logic last);
    exp_q.push_back({nz, s, last});
  endtask

  task automatic wr(input logic nz, input logic s);
    ifc.wr_valid   = 1'b1;
    ifc.wr_nonzero = nz;
    ifc.wr_sign    = s;
    step();
    ifc.wr_valid   = 1'b0;
    ifc.wr_nonzero = 1'b0;
    ifc.wr_sign    = 1'b0;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic pulse_gen_done();
    ifc.gen_done = 1'b1;
    step();
    ifc.gen_done = 1'b0;
  endtask

  task automatic pop(input int n);
    ifc.rd_req = 1'b1;
    repeat (n) step();
    ifc.rd_req = 1'b0;
  endtask

  initial begin
    logic [2:0] e;
    logic [2:0] got;
    n_vec = 0;
    n_err = 0;
    done_rises = 0;
    ifc.start = 1'b0; ifc.wr_valid = 1'b0; ifc.wr_nonzero = 1'b0;
    ifc.wr_sign = 1'b0; ifc.gen_done = 1'b0; ifc.rd_req = 1'b0;
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (ifc.rd_valid) begin
          got = {ifc.rd_nonzero, ifc.rd_sign, ifc.rd_last};
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rd_valid: got digit %b expected none (t=%0t)", got, $time);
          end else begin
            e = exp_q.pop_front();
            chk("rd_digit{nz,sign,last}", int'(got), int'(e));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) step();
    chk("rst_suspend", ifc.suspend, 0);
    chk("rst_rd_valid", ifc.rd_valid, 0);
    chk("rst_length", ifc.length, 0);
    chk("rst_weight", ifc.weight, 0);
    chk("rst_length_even", ifc.length_even, 1);
    chk("rst_ready", ifc.ready, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_overflow", ifc.overflow, 0);
    rst = 1'b1;
    step();

    // T1: +1,0,-1,0,0 LSB first; two zeros trimmed
    pulse_start();
    wr(1, 0); wr(0, 0); wr(1, 1); wr(0, 0); wr(0, 0);
    pulse_gen_done();
    step(); step();
    chk("t1_ready_after_2_trim", ifc.ready, 0);
    step();
    chk("t1_ready_after_latch", ifc.ready, 1);
    chk("t1_length", ifc.length, 3);
    chk("t1_weight", ifc.weight, 2);
    chk("t1_length_even", ifc.length_even, 0);
    push_exp(1, 1, 0); push_exp(0, 0, 0); push_exp(1, 0, 1);
    pop(3);
    chk("t1_done_with_last", ifc.done, 0);
    step();
    chk("t1_done_next", ifc.done, 1);
    chk("t1_overflow", ifc.overflow, 0);

    // T3: empty scalar
    pulse_start();
    pulse_gen_done();
    step();
    chk("t3_ready", ifc.ready, 1);
    step();
    chk("t3_done", ifc.done, 1);
    chk("t3_length", ifc.length, 0);
    chk("t3_length_even", ifc.length_even, 1);
    chk("t3_weight", ifc.weight, 0);

    // T2: fill to DEPTH, then one dropped write
    pulse_start();
    wr(1, 0); wr(1, 1); wr(0, 0); wr(1, 0);
    wr(0, 0); wr(0, 0); wr(1, 1);
    chk("t2_suspend_at_7", ifc.suspend, 0);
    wr(1, 0);
    chk("t2_suspend_full", ifc.suspend, 1);
    chk("t2_overflow_before", ifc.overflow, 0);
    wr(1, 1);
    chk("t2_overflow_dropped", ifc.overflow, 1);
    chk("t2_weight_unchanged", ifc.weight, 5);
    pulse_gen_done();
    step();
    chk("t2_ready", ifc.ready, 1);
    chk("t2_length", ifc.length, 8);
    chk("t2_length_even", ifc.length_even, 1);

    // T5: pop 4 of 8, restart mid-DRAIN
    push_exp(1, 0, 0); push_exp(1, 1, 0); push_exp(0, 0, 0); push_exp(0, 0, 0);
    pop(4);
    pulse_start();
    chk("t5_ready", ifc.ready, 0);
    chk("t5_suspend", ifc.suspend, 0);
    chk("t5_overflow_cleared", ifc.overflow, 0);
    chk("t5_length_cleared", ifc.length, 0);
    chk("t5_weight_cleared", ifc.weight, 0);
    wr(0, 1);          // 01 encodes zero, sign must read back 0
    wr(1, 1);
    pulse_gen_done();
    step();
    chk("t5_length", ifc.length, 2);
    chk("t5_weight", ifc.weight, 1);
    push_exp(1, 1, 0); push_exp(0, 0, 1);
    pop(2);
    step();
    chk("t5_done", ifc.done, 1);

    // T6: rd_req held for 5 cycles with length 3
    pulse_start();
    wr(0, 0); wr(1, 0); wr(1, 1);
    pulse_gen_done();
    step();
    chk("t6_length", ifc.length, 3);
    push_exp(1, 1, 0); push_exp(1, 0, 0); push_exp(0, 0, 1);
    ifc.rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic was_done;
      was_done = ifc.done;
      step();
      if (ifc.done && !was_done) done_rises++;
    end
    ifc.rd_req = 1'b0;
    chk("t6_done_rises", done_rises, 1);
    chk("t6_done_level", ifc.done, 1);

    // T4: synchronous reset mid-DRAIN
    pulse_start();
    wr(1, 0); wr(1, 0); wr(1, 1);
    pulse_gen_done();
    step();
    push_exp(1, 1, 0);
    pop(1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t4_rd_valid", ifc.rd_valid, 0);
    chk("t4_rd_nonzero", ifc.rd_nonzero, 0);
    chk("t4_rd_sign", ifc.rd_sign, 0);
    chk("t4_ready", ifc.ready, 0);
    chk("t4_length", ifc.length, 0);
    chk("t4_weight", ifc.weight, 0);
    chk("t4_length_even", ifc.length_even, 1);
    pop(3);
    chk("t4_ready_idle", ifc.ready, 0);
    chk("t4_done_idle", ifc.done, 0);
    wr(1, 0);
    chk("t4_overflow_idle_write", ifc.overflow, 1);
    pulse_start();
    chk("t4_overflow_start", ifc.overflow, 0);

    step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
